// File: rtl/td4_ctrl_pkg.sv
// Shared definitions for the TD4 run controller: state encoding, address width
// and the state-to-output decode used by the controller's output process.
package td4_ctrl_pkg;

  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_STEP  = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  typedef struct packed {
    logic cpu_rst;
    logic cpu_en;
    logic load_ready;
    logic halted;
  } ctrl_out_t;

  function automatic ctrl_out_t decode_outputs(input state_t s);
    ctrl_out_t o;
    o.cpu_rst    = (s == ST_IDLE) || (s == ST_LOAD);
    o.cpu_en     = (s == ST_RUN) || (s == ST_STEP);
    o.load_ready = (s == ST_LOAD);
    o.halted     = (s == ST_HALT);
    return o;
  endfunction

endpackage

// File: rtl/td4_halt_detect.sv
// Flags a jump-to-self: the CPU was enabled last cycle and its program counter
// did not move.
module td4_halt_detect
  import td4_ctrl_pkg::*;
#(
  parameter int HALT_DETECT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              cpu_rst,
  input  logic [ADDR_W-1:0] cpu_adr,
  output logic              halt
);

  logic [ADDR_W-1:0] prev_adr_reg;
  logic              prev_valid_reg;
  logic              en_prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_adr_reg   <= '0;
      prev_valid_reg <= 1'b0;
      en_prev_reg    <= 1'b0;
    end else begin
      en_prev_reg <= cpu_en;
      if (cpu_en) begin
        prev_adr_reg   <= cpu_adr;
        prev_valid_reg <= 1'b1;
      end else if (cpu_rst) begin
        prev_valid_reg <= 1'b0;
      end
    end
  end

  generate
    if (HALT_DETECT != 0) begin : g_detect
      assign halt = en_prev_reg && prev_valid_reg && (cpu_adr == prev_adr_reg);
    end else begin : g_no_detect
      assign halt = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/td4_run_ctrl.sv
// TD4 run controller: program loading into the ROM and run/pause/step/halt
// sequencing of the CPU clock enable and reset.
module td4_run_ctrl
  import td4_ctrl_pkg::*;
#(
  parameter int HALT_DETECT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              stop_req,
  input  logic [ADDR_W-1:0] cpu_adr,
  output logic              cpu_rst,
  output logic              cpu_en,
  output logic [2:0]        state,
  output logic              halted
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic              halt;
  ctrl_out_t         outs;

  td4_halt_detect #(
    .HALT_DETECT(HALT_DETECT)
  ) u_halt_detect (
    .clk    (clk),
    .reset  (reset),
    .cpu_en (cpu_en),
    .cpu_rst(cpu_rst),
    .cpu_adr(cpu_adr),
    .halt   (halt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      wr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
    end
  end

  // Each branch tests requests in priority order, skipping ones not legal here.
  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (load_start) begin
          state_next  = ST_LOAD;
          wr_ptr_next = '0;
        end else if (run_req) begin
          state_next = ST_RUN;
        end else if (step_req) begin
          state_next = ST_STEP;
        end
      end
      ST_LOAD: begin
        if (stop_req) begin
          state_next  = ST_IDLE;
          wr_ptr_next = '0;
        end else if (load_valid) begin
          wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
          if (wr_ptr_reg == '1) state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (load_start) begin
          state_next  = ST_LOAD;
          wr_ptr_next = '0;
        end else if (stop_req) begin
          state_next = ST_PAUSE;
        end else if (halt) begin
          state_next = ST_HALT;
        end
      end
      ST_PAUSE: begin
        if (load_start) begin
          state_next  = ST_LOAD;
          wr_ptr_next = '0;
        end else if (run_req) begin
          state_next = ST_RUN;
        end else if (step_req) begin
          state_next = ST_STEP;
        end
      end
      ST_STEP: begin
        state_next = halt ? ST_HALT : ST_PAUSE;
      end
      ST_HALT: begin
        if (load_start) begin
          state_next  = ST_LOAD;
          wr_ptr_next = '0;
        end else if (run_req) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next  = ST_IDLE;
        wr_ptr_next = '0;
      end
    endcase
  end

  always_comb begin
    outs       = decode_outputs(state_reg);
    cpu_rst    = outs.cpu_rst;
    cpu_en     = outs.cpu_en;
    load_ready = outs.load_ready;
    halted     = outs.halted;
  end

  assign state     = state_reg;
  assign mem_we    = load_valid & load_ready;
  assign mem_wdata = load_data;
  assign mem_addr  = wr_ptr_reg;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Directed bench for td4_run_ctrl; ROM writes are checked against a scoreboard
// queue and a small PC model stands in for the CPU.
module tb_td4_run_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_STEP  = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       run_req = 1'b0;
  logic       step_req = 1'b0;
  logic       stop_req = 1'b0;
  logic       load_ready, mem_we, cpu_rst, cpu_en, halted;
  logic [3:0] mem_addr, cpu_adr;
  logic [7:0] mem_wdata;
  logic [2:0] state;
  logic [3:0] pc;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  td4_run_ctrl #(
    .HALT_DETECT(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .run_req   (run_req),
    .step_req  (step_req),
    .stop_req  (stop_req),
    .cpu_adr   (cpu_adr),
    .cpu_rst   (cpu_rst),
    .cpu_en    (cpu_en),
    .state     (state),
    .halted    (halted)
  );

  // CPU stand-in: program 0,1,2,3 then jump-to-self at 3.
  always_ff @(posedge clk) begin
    if (cpu_rst) pc <= 4'd0;
    else if (cpu_en) pc <= (pc == 4'd3) ? pc : pc + 4'd1;
  end
  assign cpu_adr = pc;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic ls, input logic sr, input logic rr, input logic st);
    load_start = ls;
    stop_req   = sr;
    run_req    = rr;
    step_req   = st;
    cyc();
    load_start = 1'b0;
    stop_req   = 1'b0;
    run_req    = 1'b0;
    step_req   = 1'b0;
  endtask

  task automatic load_cycle(input logic v, input logic [7:0] d, input logic exp_we,
                            input logic [3:0] exp_addr);
    logic [11:0] e;
    load_valid = v;
    load_data  = d;
    if (exp_we) exp_q.push_back({exp_addr, d});
    #1;
    check("mem_we", 16'(mem_we), 16'(exp_we));
    if (mem_we && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("mem_write", 16'({mem_addr, mem_wdata}), 16'(e));
    end
    cyc();
    load_valid = 1'b0;
  endtask

  initial begin
    int en_cnt;
    #12;
    check("rst_state", 16'(state), 16'(S_IDLE));
    check("rst_cpu_rst", 16'(cpu_rst), 16'd1);
    check("rst_cpu_en", 16'(cpu_en), 16'd0);
    check("rst_load_ready", 16'(load_ready), 16'd0);
    check("rst_mem_we", 16'(mem_we), 16'd0);
    check("rst_mem_addr", 16'(mem_addr), 16'd0);
    check("rst_halted", 16'(halted), 16'd0);
    reset = 1'b0;
    cyc();

    req(1'b0, 1'b1, 1'b0, 1'b0);
    check("idle_ignore_stop", 16'(state), 16'(S_IDLE));

    // Full 16-byte load with wrap back to IDLE
    req(1'b1, 1'b0, 1'b0, 1'b0);
    check("load_state", 16'(state), 16'(S_LOAD));
    check("load_ready", 16'(load_ready), 16'd1);
    check("load_cpu_rst", 16'(cpu_rst), 16'd1);
    for (int i = 0; i < 16; i++) load_cycle(1'b1, 8'(i), 1'b1, 4'(i));
    check("load_done_state", 16'(state), 16'(S_IDLE));
    check("load_done_ready", 16'(load_ready), 16'd0);
    check("load_done_addr", 16'(mem_addr), 16'd0);
    load_cycle(1'b1, 8'h55, 1'b0, 4'd0);

    // Gapped load aborted by stop_req after 5 bytes
    req(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++)
      load_cycle((k % 2) == 0, 8'(8'hA0 + k), (k % 2) == 0, 4'(k / 2));
    check("abort_pre_addr", 16'(mem_addr), 16'd5);
    req(1'b0, 1'b1, 1'b0, 1'b0);
    check("abort_state", 16'(state), 16'(S_IDLE));
    check("abort_wr_ptr", 16'(mem_addr), 16'd0);

    // Run until the jump-to-self at address 3
    req(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("run_state", 16'(state), 16'(S_RUN));
      check("run_cpu_en", 16'(cpu_en), 16'd1);
      check("run_cpu_adr", 16'(cpu_adr), 16'((i > 3) ? 3 : i));
      cyc();
    end
    check("halt_state", 16'(state), 16'(S_HALT));
    check("halt_halted", 16'(halted), 16'd1);
    check("halt_cpu_en", 16'(cpu_en), 16'd0);
    check("halt_cpu_rst", 16'(cpu_rst), 16'd0);
    req(1'b0, 1'b1, 1'b0, 1'b1);
    check("halt_ignore", 16'(state), 16'(S_HALT));
    req(1'b0, 1'b0, 1'b1, 1'b0);
    check("halt_to_idle", 16'(state), 16'(S_IDLE));
    check("halt_idle_rst", 16'(cpu_rst), 16'd1);
    req(1'b0, 1'b0, 1'b1, 1'b0);
    check("rerun_state", 16'(state), 16'(S_RUN));
    check("rerun_adr", 16'(cpu_adr), 16'd0);
    req(1'b0, 1'b1, 1'b0, 1'b0);
    check("pause_state", 16'(state), 16'(S_PAUSE));
    check("pause_cpu_en", 16'(cpu_en), 16'd0);
    check("pause_cpu_rst", 16'(cpu_rst), 16'd0);
    check("pause_adr", 16'(cpu_adr), 16'd1);

    // Three single steps, four cycles apart
    en_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step_req = ((k % 4) == 0);
      cyc();
      step_req = 1'b0;
      check("step_state", 16'(state), 16'(((k % 4) == 0) ? S_STEP : S_PAUSE));
      en_cnt += int'(cpu_en);
    end
    check("step_en_count", 16'(en_cnt), 16'd3);
    check("step_adr", 16'(cpu_adr), 16'd3);

    // load_start beats stop_req in RUN
    req(1'b0, 1'b0, 1'b1, 1'b0);
    check("run2_state", 16'(state), 16'(S_RUN));
    req(1'b1, 1'b1, 1'b0, 1'b0);
    check("prio_state", 16'(state), 16'(S_LOAD));
    check("prio_cpu_rst", 16'(cpu_rst), 16'd1);
    req(1'b0, 1'b1, 1'b0, 1'b0);
    check("prio_abort", 16'(state), 16'(S_IDLE));

    // Asynchronous reset during STEP
    req(1'b0, 1'b0, 1'b0, 1'b1);
    check("step2_state", 16'(state), 16'(S_STEP));
    check("step2_cpu_en", 16'(cpu_en), 16'd1);
    reset = 1'b1;
    #1;
    check("rst_step_cpu_en", 16'(cpu_en), 16'd0);
    check("rst_step_cpu_rst", 16'(cpu_rst), 16'd1);
    check("rst_step_state", 16'(state), 16'(S_IDLE));
    cyc();
    reset = 1'b0;
    cyc();

    // Asynchronous reset during LOAD
    req(1'b1, 1'b0, 1'b0, 1'b0);
    load_cycle(1'b1, 8'h11, 1'b1, 4'd0);
    load_valid = 1'b1;
    load_data  = 8'h22;
    reset = 1'b1;
    #1;
    check("rst_load_we", 16'(mem_we), 16'd0);
    check("rst_load_ready", 16'(load_ready), 16'd0);
    check("rst_load_addr", 16'(mem_addr), 16'd0);
    load_valid = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    check("rst_load_state", 16'(state), 16'(S_IDLE));

    check("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/td4_run_ctrl.md
TD4_RUN_CTRL -- requirements
Module: td4_run_ctrl

Interface
REQ-001 SHALL have parameter: HALT_DETECT, default 1, 1 = enable self-jump halt detection, 0 = never enter HALT.
REQ-002 SHALL have port: clk  in  1  system clock, rising edge.
REQ-003 SHALL have port: reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: load_start  in  1  request program load, single-cycle pulse.
REQ-005 SHALL have ports: load_valid  in  1  and  load_data  in  8, the loader byte stream.
REQ-006 SHALL have port: load_ready  out  1  controller accepts a load byte this cycle.
REQ-007 SHALL have ports: mem_we  out  1, mem_addr  out  4, mem_wdata  out  8, the program ROM write port.
REQ-008 SHALL have ports: run_req, step_req, stop_req  in  1 each, operator requests, single-cycle pulses.
REQ-009 SHALL have port: cpu_adr  in  4  CPU program counter (instruction address).
REQ-010 SHALL have ports: cpu_rst  out  1  CPU reset, and cpu_en  out  1  CPU clock enable.
REQ-011 SHALL have ports: state  out  3  current state encoding, and halted  out  1  HALT indication.

Function
REQ-012 SHALL implement the states IDLE=0, LOAD=1, RUN=2, PAUSE=3, STEP=4 and HALT=5, held in a single state register.
REQ-013 SHALL decode outputs from state only: cpu_rst=1 in IDLE and LOAD; cpu_en=1 in RUN and STEP; load_ready=1 in LOAD; halted=1 in HALT; all other cases 0.
REQ-014 SHALL drive the ROM write port combinationally: mem_we = load_valid & load_ready; mem_wdata = load_data; mem_addr = wr_ptr (4-bit).
REQ-015 SHALL resolve simultaneous requests with priority load_start > stop_req > run_req > step_req, evaluating only the highest-priority request that is legal in the current state.
REQ-016 SHALL make these transitions from IDLE: load_start -> LOAD with wr_ptr=0; run_req -> RUN; step_req -> STEP.
REQ-017 SHALL, in LOAD, increment wr_ptr on each accepted byte; on accepting the byte at wr_ptr=15, SHALL wrap wr_ptr to 0 and go to IDLE, so load_ready is low on the next cycle.
REQ-018 SHALL, in LOAD, make stop_req abort the load to IDLE with wr_ptr=0; bytes already written are not undone; load_start, run_req and step_req are ignored.
REQ-019 SHALL make these transitions from RUN: stop_req -> PAUSE; load_start -> LOAD; halt detected -> HALT.
REQ-020 SHALL, in PAUSE, hold cpu_rst=0 and cpu_en=0 with CPU state retained, and transition: step_req -> STEP; run_req -> RUN; load_start -> LOAD.
REQ-021 SHALL leave STEP after exactly one cycle: to HALT if halt is detected, otherwise to PAUSE, giving exactly one CPU-enabled clock per step_req.
REQ-022 SHALL, in HALT, transition: run_req -> IDLE, which resets the CPU so a further run_req restarts at address 0; load_start -> LOAD; stop_req and step_req are ignored.
REQ-023 SHALL detect a halt (HALT_DETECT=1) when cpu_en was 1 in the previous cycle, prev_valid=1, and cpu_adr equals prev_adr, i.e. a jump-to-self.
REQ-024 SHALL capture prev_adr <= cpu_adr and set prev_valid=1 on every cycle where cpu_en=1; prev_valid SHALL clear whenever cpu_rst=1.
REQ-025 SHALL ignore request pulses that arrive in states where they are not listed as legal.

Reset
REQ-026 SHALL, on reset, asynchronously set state=IDLE, wr_ptr=0, prev_adr=0 and prev_valid=0, giving outputs cpu_rst=1, cpu_en=0, load_ready=0, mem_we=0, mem_addr=0 and halted=0.
REQ-027 SHALL, when reset is asserted mid-LOAD, mid-RUN or mid-STEP, abandon the operation immediately, with no further mem_we and no further cpu_en.

Structure
REQ-028 SHALL place the state encoding constants and the 4-bit address width constant in the shared package td4_ctrl_pkg.
REQ-029 SHALL implement halt detection as the sub-module td4_halt_detect (inputs clk, reset, cpu_en, cpu_rst, cpu_adr; output halt), instantiated once.

Verification
REQ-030 SHALL cover: reset, then load_start, then 16 consecutive bytes 0x00..0x0F -> mem_we on 16 cycles with mem_addr 0..15, state back to IDLE, load_ready=0.
REQ-031 SHALL cover: LOAD with load_valid toggling every other cycle and stop_req after 5 accepted bytes -> exactly 5 writes (addr 0..4), state=IDLE, wr_ptr=0.
REQ-032 SHALL cover: run_req with a cpu_adr model stepping 0,1,2,3,3 -> state RUN until the repeated 3, then HALT, halted=1, cpu_en=0.
REQ-033 SHALL cover: from PAUSE, three step_req pulses 4 cycles apart -> exactly 3 single cycles of cpu_en=1, returning to PAUSE each time.
REQ-034 SHALL cover: load_start and stop_req asserted together in RUN -> LOAD taken and cpu_rst=1 on the next cycle.
REQ-035 SHALL cover: reset asserted during STEP -> cpu_en=0 and cpu_rst=1 immediately, with state=IDLE.
